// File: rtl/alu_multicycle.sv
// Multi-cycle ALU.
// Single-cycle ops (add/sub/logic/not/compare, immediates) register their outputs on the
// accepting edge. MUL (shift-add) and DIV (restoring) run one iteration per clock for WIDTH
// clocks, with operands latched at acceptance.
//
// Ports:
//   clock_i        single clock, rising edge
//   reset_ni       asynchronous active-low reset
//   start_i        request; accepted only on an edge where busy_o = 0
//   data_a_i/b_i   operands A and B
//   alu_control_i  opcode class: 000 ADDI, 001 SUBI, 010 TYPE_R, 011 ANDI, 100 ORI
//   func_i         TYPE_R function code
//   busy_o         high while an iterative MUL/DIV is running
//   done_o         one-cycle pulse marking valid result/result_hi/flag
//   result_o       sum, difference, logic value, product low half or quotient
//   result_hi_o    product high half or remainder, else 0
//   flag_o         000 none, 001 equal, 010 exception, 011 overflow, 100 underflow, 101 above
module alu_multicycle #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic [WIDTH-1:0] data_a_i,
    input  logic [WIDTH-1:0] data_b_i,
    input  logic [2:0]       alu_control_i,
    input  logic [5:0]       func_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic [WIDTH-1:0] result_hi_o,
    output logic [2:0]       flag_o
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CntInit = CW'(WIDTH);

    localparam logic [2:0] FlagNone  = 3'b000;
    localparam logic [2:0] FlagEqual = 3'b001;
    localparam logic [2:0] FlagExc   = 3'b010;
    localparam logic [2:0] FlagOver  = 3'b011;
    localparam logic [2:0] FlagUnder = 3'b100;
    localparam logic [2:0] FlagAbove = 3'b101;

    typedef enum logic [1:0] {StIdle, StMul, StDiv} state_e;
    typedef enum logic [1:0] {OpSingle, OpMul, OpDiv} op_e;

    state_e           state_q, state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic [2:0]       flag_q, flag_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    // MUL: acc_hi = partial product, acc_lo = multiplier shifting out, op = multiplicand.
    // DIV: acc_hi = partial remainder, acc_lo = dividend shifting into quotient, op = divisor.
    logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
    logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
    logic [WIDTH-1:0] op_q, op_d;

    // Single-cycle arithmetic with signed overflow detection
    logic [WIDTH-1:0] sum, diff;
    logic             add_ovf, sub_ovf;
    logic [2:0]       add_flag, sub_flag;

    assign sum      = data_a_i + data_b_i;
    assign diff     = data_a_i - data_b_i;
    assign add_ovf  = (data_a_i[WIDTH-1] == data_b_i[WIDTH-1]) &&
                      (sum[WIDTH-1] != data_a_i[WIDTH-1]);
    assign sub_ovf  = (data_a_i[WIDTH-1] != data_b_i[WIDTH-1]) &&
                      (diff[WIDTH-1] != data_a_i[WIDTH-1]);
    assign add_flag = add_ovf ? (data_a_i[WIDTH-1] ? FlagUnder : FlagOver) : FlagNone;
    assign sub_flag = sub_ovf ? (data_a_i[WIDTH-1] ? FlagUnder : FlagOver) : FlagNone;

    // One shift-add multiply step
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_nx, mul_lo_nx;

    assign mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, op_q} : '0);
    assign mul_hi_nx = mul_sum[WIDTH:1];
    assign mul_lo_nx = {mul_sum[0], acc_lo_q[WIDTH-1:1]};

    // One restoring divide step
    logic [WIDTH:0]   div_shift, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_hi_nx, div_lo_nx;

    assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, op_q};
    assign div_ge    = div_shift >= {1'b0, op_q};
    assign div_hi_nx = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
    assign div_lo_nx = {acc_lo_q[WIDTH-2:0], div_ge};

    // Opcode decode for the request currently on the inputs
    op_e              dec_op;
    logic [WIDTH-1:0] dec_res, dec_hi;
    logic [2:0]       dec_flag;

    always_comb begin
        dec_op   = OpSingle;
        dec_res  = '0;
        dec_hi   = '0;
        dec_flag = FlagNone;
        case (alu_control_i)
            3'b000: begin
                dec_res  = sum;
                dec_flag = add_flag;
            end
            3'b001: begin
                dec_res  = diff;
                dec_flag = sub_flag;
            end
            3'b010: begin
                case (func_i)
                    6'b100000: begin
                        dec_res  = sum;
                        dec_flag = add_flag;
                    end
                    6'b100010: begin
                        dec_res  = diff;
                        dec_flag = sub_flag;
                    end
                    6'b000010: dec_op = OpMul;
                    6'b000001: begin
                        // Divide by zero finishes at once and hands back the dividend
                        if (data_b_i == '0) begin
                            dec_hi   = data_a_i;
                            dec_flag = FlagExc;
                        end else begin
                            dec_op = OpDiv;
                        end
                    end
                    6'b100100: dec_res = data_a_i & data_b_i;
                    6'b100101: dec_res = data_a_i | data_b_i;
                    6'b100111: dec_res = ~data_b_i;
                    6'b101010: begin
                        if (data_a_i == data_b_i) begin
                            dec_flag = FlagEqual;
                        end else if (data_a_i > data_b_i) begin
                            dec_flag = FlagAbove;
                        end
                    end
                    default: dec_flag = FlagExc;
                endcase
            end
            3'b011:  dec_res = data_a_i & data_b_i;
            3'b100:  dec_res = data_a_i | data_b_i;
            default: dec_flag = FlagExc;
        endcase
    end

    // Next-state logic
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        flag_d      = flag_q;
        cnt_d       = cnt_q;
        acc_hi_d    = acc_hi_q;
        acc_lo_d    = acc_lo_q;
        op_d        = op_q;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    case (dec_op)
                        OpMul: begin
                            state_d  = StMul;
                            busy_d   = 1'b1;
                            cnt_d    = CntInit;
                            acc_hi_d = '0;
                            acc_lo_d = data_b_i;
                            op_d     = data_a_i;
                        end
                        OpDiv: begin
                            state_d  = StDiv;
                            busy_d   = 1'b1;
                            cnt_d    = CntInit;
                            acc_hi_d = '0;
                            acc_lo_d = data_a_i;
                            op_d     = data_b_i;
                        end
                        default: begin
                            done_d      = 1'b1;
                            result_d    = dec_res;
                            result_hi_d = dec_hi;
                            flag_d      = dec_flag;
                        end
                    endcase
                end
            end
            StMul: begin
                acc_hi_d = mul_hi_nx;
                acc_lo_d = mul_lo_nx;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = StIdle;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    result_d    = mul_lo_nx;
                    result_hi_d = mul_hi_nx;
                    flag_d      = (mul_hi_nx != '0) ? FlagOver : FlagNone;
                end
            end
            StDiv: begin
                acc_hi_d = div_hi_nx;
                acc_lo_d = div_lo_nx;
                cnt_d    = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d     = StIdle;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    result_d    = div_lo_nx;
                    result_hi_d = div_hi_nx;
                    flag_d      = FlagNone;
                end
            end
            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= StIdle;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            flag_q      <= FlagNone;
            cnt_q       <= '0;
            acc_hi_q    <= '0;
            acc_lo_q    <= '0;
            op_q        <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            flag_q      <= flag_d;
            cnt_q       <= cnt_d;
            acc_hi_q    <= acc_hi_d;
            acc_lo_q    <= acc_lo_d;
            op_q        <= op_d;
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign result_o    = result_q;
    assign result_hi_o = result_hi_q;
    assign flag_o      = flag_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Scoreboard bench for alu_multicycle (WIDTH=32): stimulus pushes expected responses,
// a negedge monitor pops and compares on every done pulse.
module tb_alu_multicycle;

    localparam int unsigned W = 32;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a     = '0;
    logic [W-1:0] b     = '0;
    logic [2:0]   ctrl  = '0;
    logic [5:0]   fn    = '0;
    logic         busy, done;
    logic [W-1:0] res, res_hi;
    logic [2:0]   flag;

    alu_multicycle #(.WIDTH(W)) dut (
        .clock_i      (clk),
        .reset_ni     (rst_n),
        .start_i      (start),
        .data_a_i     (a),
        .data_b_i     (b),
        .alu_control_i(ctrl),
        .func_i       (fn),
        .busy_o       (busy),
        .done_o       (done),
        .result_o     (res),
        .result_hi_o  (res_hi),
        .flag_o       (flag)
    );

    always #5 clk = ~clk;

    int total  = 0;
    int bad    = 0;
    int n_done = 0;

    logic [W-1:0] q_r[$];
    logic [W-1:0] q_h[$];
    logic [2:0]   q_f[$];
    string        q_n[$];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst_n && done === 1'b1) begin
            n_done++;
            if (q_r.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got done=1 expected no pending op (t=%0t)", $time);
            end else begin
                string nm;
                nm = q_n.pop_front();
                check({nm, ".result"}, 64'(res), 64'(q_r.pop_front()));
                check({nm, ".result_hi"}, 64'(res_hi), 64'(q_h.pop_front()));
                check({nm, ".flag"}, 64'(flag), 64'(q_f.pop_front()));
            end
        end
    end

    task automatic push_exp(input string nm, input logic [W-1:0] er, input logic [W-1:0] eh,
                            input logic [2:0] ef);
        q_n.push_back(nm);
        q_r.push_back(er);
        q_h.push_back(eh);
        q_f.push_back(ef);
    endtask

    // Drive one request for a single edge; inputs are scrambled afterwards to prove latching.
    task automatic issue(input logic [2:0] c, input logic [5:0] f, input logic [W-1:0] ia,
                         input logic [W-1:0] ib, input string nm, input logic [W-1:0] er,
                         input logic [W-1:0] eh, input logic [2:0] ef, input bit push);
        @(negedge clk);
        ctrl  = c;
        fn    = f;
        a     = ia;
        b     = ib;
        start = 1'b1;
        if (push) push_exp(nm, er, eh, ef);
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
        ctrl  = 3'b010;
        fn    = 6'b100010;
    endtask

    task automatic wait_for(input int snap, input int budget, input string nm);
        for (int i = 0; i < budget; i++) begin
            if (n_done > snap) return;
            @(negedge clk);
            #1;
        end
        if (n_done <= snap) begin
            total++;
            bad++;
            $display("FAIL %s.timeout: got no done expected done within %0d cycles", nm, budget);
        end
    endtask

    task automatic op(input logic [2:0] c, input logic [5:0] f, input logic [W-1:0] ia,
                      input logic [W-1:0] ib, input string nm, input logic [W-1:0] er,
                      input logic [W-1:0] eh, input logic [2:0] ef);
        int snap;
        snap = n_done;
        issue(c, f, ia, ib, nm, er, eh, ef, 1'b1);
        wait_for(snap, 80, nm);
    endtask

    // Iterative op: also measures how many cycles busy stays high
    task automatic op_iter(input logic [5:0] f, input logic [W-1:0] ia, input logic [W-1:0] ib,
                           input string nm, input logic [W-1:0] er, input logic [W-1:0] eh,
                           input logic [2:0] ef);
        int snap;
        int cyc;
        snap = n_done;
        cyc  = 0;
        issue(3'b010, f, ia, ib, nm, er, eh, ef, 1'b1);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (busy !== 1'b1) break;
            cyc++;
        end
        check({nm, ".busy_cycles"}, 64'(cyc), 64'd32);
        wait_for(snap, 80, nm);
    endtask

    initial begin
        int snap;
        #1 rst_n = 1'b0;
        #12;
        check("rst.busy", 64'(busy), 64'd0);
        check("rst.done", 64'(done), 64'd0);
        check("rst.result", 64'(res), 64'd0);
        check("rst.result_hi", 64'(res_hi), 64'd0);
        check("rst.flag", 64'(flag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Signed overflow on add/sub, with result hold after the done pulse
        op(3'b010, 6'b100000, 32'h7FFF_FFFF, 32'h1, "add_ovf", 32'h8000_0000, 0, 3'b011);
        @(negedge clk);
        check("hold.done", 64'(done), 64'd0);
        check("hold.result", 64'(res), 64'h8000_0000);
        op(3'b010, 6'b100010, 32'h8000_0000, 32'h1, "sub_unf", 32'h7FFF_FFFF, 0, 3'b100);
        op(3'b000, 6'b0, 32'h5, 32'hFFFF_FFFD, "addi", 32'h2, 0, 3'b000);
        op(3'b000, 6'b0, 32'h8000_0000, 32'h8000_0000, "addi_unf", 32'h0, 0, 3'b100);
        op(3'b001, 6'b0, 32'h0, 32'h1, "subi", 32'hFFFF_FFFF, 0, 3'b000);
        op(3'b011, 6'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, "andi", 32'hF000_F000, 0, 3'b000);
        op(3'b010, 6'b100101, 32'h0F0F_0000, 32'h0000_00FF, "or", 32'h0F0F_00FF, 0, 3'b000);
        op(3'b100, 6'b0, 32'h1200_0000, 32'h0000_0034, "ori", 32'h1200_0034, 0, 3'b000);
        op(3'b010, 6'b100111, 32'h1234_5678, 32'h0000_FFFF, "not", 32'hFFFF_0000, 0, 3'b000);

        // Unsigned compare
        op(3'b010, 6'b101010, 32'h5, 32'h5, "cmp_eq", 0, 0, 3'b001);
        op(3'b010, 6'b101010, 32'h6, 32'h5, "cmp_gt", 0, 0, 3'b101);
        op(3'b010, 6'b101010, 32'h4, 32'h5, "cmp_lt", 0, 0, 3'b000);
        op(3'b010, 6'b101010, 32'hFFFF_FFFF, 32'h1, "cmp_uns", 0, 0, 3'b101);

        // Undefined codes
        op(3'b111, 6'b100000, 32'h5, 32'h6, "bad_ctrl", 0, 0, 3'b010);
        op(3'b010, 6'b111111, 32'h5, 32'h6, "bad_func", 0, 0, 3'b010);

        // Iterative MUL/DIV
        op_iter(6'b000010, 32'h0001_0000, 32'h0001_0000, "mul_ovf", 32'h0, 32'h1, 3'b011);
        op_iter(6'b000010, 32'h1234_5678, 32'h9, "mul", 32'hA3D7_0A38, 32'h0, 3'b000);
        op_iter(6'b000001, 32'd100, 32'd7, "div", 32'd14, 32'd2, 3'b000);
        op_iter(6'b000001, 32'hFFFF_FFFF, 32'd10, "div_big", 32'h1999_9999, 32'd5, 3'b000);

        // Divide by zero completes without going busy
        snap = n_done;
        issue(3'b010, 6'b000001, 32'd9, 32'd0, "div0", 32'd0, 32'd9, 3'b010, 1'b1);
        check("div0.busy_edge", 64'(busy), 64'd0);
        @(negedge clk);
        check("div0.busy_next", 64'(busy), 64'd0);
        wait_for(snap, 10, "div0");

        // Back-to-back: ADDI accepted in the cycle MUL presents done
        op_iter(6'b000010, 32'h8000_0001, 32'h3, "mul_pre", 32'h8000_0003, 32'h1, 3'b011);
        snap = n_done;
        issue(3'b010, 6'b000010, 32'h1234_5678, 32'h9, "bb_mul", 32'hA3D7_0A38, 0, 3'b000,
              1'b1);
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done === 1'b1) break;
        end
        ctrl  = 3'b000;
        a     = 32'd10;
        b     = 32'd20;
        start = 1'b1;
        push_exp("bb_add", 32'd30, 32'd0, 3'b000);
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_for(snap + 1, 80, "bb");
        @(negedge clk);
        check("bb.done_pulse", 64'(done), 64'd0);
        check("bb.hold", 64'(res), 64'd30);

        // Reset mid-MUL with an ignored second start
        op(3'b010, 6'b000010, 32'h8000_0001, 32'h3, "mul_pre2", 32'h8000_0003, 32'h1, 3'b011);
        issue(3'b010, 6'b000010, 32'h3, 32'h5, "mul_abort", 0, 0, 0, 1'b0);
        repeat (4) @(posedge clk);
        @(negedge clk);
        a     = 32'hDEAD_BEEF;
        b     = 32'h0000_00FF;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("abort.busy_before", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("abort.busy", 64'(busy), 64'd0);
        check("abort.done", 64'(done), 64'd0);
        check("abort.result", 64'(res), 64'd0);
        check("abort.result_hi", 64'(res_hi), 64'd0);
        check("abort.flag", 64'(flag), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        op(3'b010, 6'b100000, 32'd2, 32'd3, "add_after_rst", 32'd5, 0, 3'b000);
        repeat (40) @(negedge clk);

        check("queue_empty", 64'(q_r.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_multicycle.md
ALU_MULTICYCLE -- requirements
Module: alu_multicycle

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the operand and result width; legal range is 4 to 64.
REQ-002 Port clock, input, 1, SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 Port reset, input, 1, SHALL be an asynchronous, active-low reset.
REQ-004 Port start, input, 1, SHALL request an operation; it is accepted only on a rising edge where busy=0.
REQ-005 Port data_a, input, WIDTH, SHALL be operand A.
REQ-006 Port data_b, input, WIDTH, SHALL be operand B.
REQ-007 Port alu_control, input, 3, SHALL carry the opcode class: 000 ADDI, 001 SUBI, 010 TYPE_R, 011 ANDI, 100 ORI.
REQ-008 Port func, input, 6, SHALL carry the TYPE_R function: 100000 ADD, 100010 SUB, 000010 MUL, 000001 DIV, 100100 AND, 100101 OR, 100111 NOT, 101010 CMP.
REQ-009 Port busy, output, 1, SHALL be high while an iterative MUL or DIV is in progress.
REQ-010 Port done, output, 1, SHALL be a one-cycle pulse marking valid result, result_hi and flag.
REQ-011 Port result, output, WIDTH, SHALL carry the primary result: sum, difference, logic value, product low half, or quotient.
REQ-012 Port result_hi, output, WIDTH, SHALL carry the product high half or the remainder, and 0 for all other operations.
REQ-013 Port flag, output, 3, SHALL carry the status code: 000 none, 001 equal, 010 exception, 011 overflow, 100 underflow, 101 above.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, MUL and DIV; busy=1 exactly in MUL and DIV.
REQ-015 On acceptance, operands and codes SHALL be latched; input changes while busy=1 SHALL have no effect.
REQ-016 A start while busy=1 SHALL be ignored, not queued.
REQ-017 Single-cycle operations (ADD, SUB, AND, OR, NOT, CMP, ADDI, SUBI, ANDI, ORI) SHALL register their outputs on the accepting edge, assert done for the following cycle, and stay in IDLE.
REQ-018 ADD/ADDI and SUB/SUBI SHALL use two's-complement signed overflow detection:
- positive overflow -> flag 011
- negative overflow -> flag 100
- otherwise -> flag 000
- result is always the WIDTH-bit wrapped value
REQ-019 AND/ANDI, OR/ORI and NOT (~data_b) SHALL return flag 000.
REQ-020 CMP SHALL be an unsigned comparison:
- A==B -> flag 001
- A>B -> flag 101
- A<B -> flag 000
- result = 0 in all cases
REQ-021 MUL SHALL be an unsigned shift-add taking one iteration per clock for WIDTH iterations.
- done SHALL pulse in the cycle after the WIDTH-th post-accept edge.
- {result_hi, result} = A*B.
- flag = 011 if result_hi != 0, else 000.
REQ-022 DIV SHALL be an unsigned restoring division with the same WIDTH-iteration timing as MUL; result = quotient, result_hi = remainder, flag = 000.
REQ-023 DIV with B=0 SHALL NOT enter state DIV; it SHALL complete as a single-cycle operation with result=0, result_hi=A, flag=010.
REQ-024 An undefined alu_control or func value SHALL complete as a single-cycle operation with result=0, result_hi=0, flag=010.
REQ-025 done SHALL be asserted only in IDLE, so start may be accepted in the same cycle as done (back-to-back operation).
REQ-026 result, result_hi and flag SHALL hold their last values until the next completion.
REQ-027 The iteration counter SHALL be $clog2(WIDTH+1) bits wide and SHALL count down from WIDTH to 0, with no wrap.

Reset
REQ-028 When reset=0, the FSM SHALL go to IDLE immediately, aborting any operation in progress.
REQ-029 While reset=0, busy, done, result, result_hi, flag and the counter SHALL be 0.
REQ-030 A start coincident with the releasing edge of reset SHALL be accepted normally.

Verification (WIDTH=32)
REQ-031 ADD 0x7FFFFFFF+0x1 -> one edge later done=1, result=0x80000000, flag=011; SUB 0x80000000-0x1 -> result=0x7FFFFFFF, flag=100.
REQ-032 MUL 0x00010000*0x00010000 -> busy high for 32 cycles, then done=1, result=0, result_hi=1, flag=011.
REQ-033 DIV 100/7 -> after 32 cycles result=14, result_hi=2, flag=000; DIV 9/0 -> one edge later result=0, result_hi=9, flag=010, busy never high.
REQ-034 CMP (5,5) -> flag 001; CMP (6,5) -> flag 101; CMP (4,5) -> flag 000; result=0 for all three.
REQ-035 MUL started, a second start with changed operands issued at iteration 5, then reset pulsed low at iteration 10 -> second start ignored; busy, done, result, result_hi and flag all 0 at once; a fresh ADD 2+3 after release gives result=5.
REQ-036 Back-to-back: ADD accepted in the cycle MUL asserts done -> MUL outputs valid for one cycle, then ADD result on the next done pulse.
